lcd_row_arbiter: RTL

Owns the two 16-character row buffers (row_A, row_B) that feed LCD_module. Shares write access among N_REQ requesters, such as the Fibonacci sequencer, a status display or a button handler. Each requester submits single-cell writes over a valid/ready handshake, and a round-robin arbiter serialises them. Also provides global clear, a hold, and a one-cycle update pulse for the display path.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/lcd_row_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and character helpers for the LCD row buffers
package lcd_pkg;

    localparam int ROW_CHARS = 16;
    localparam int CHAR_W    = 8;
    localparam int ROW_W     = 128;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // 0..9 map onto "0".."9", 10..15 onto "A".."F"
    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Column 0 is the most significant byte of the row
    function automatic int col_lsb(input logic [3:0] col);
        return ROW_W - CHAR_W * (int'(col) + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lcd_row_arbiter.sv
// rtl/lcd_row_arbiter.sv - two 16-char LCD row buffers shared by round-robin requesters
module lcd_row_arbiter
    import lcd_pkg::*;
#(
    parameter int           N_REQ  = 4,
    parameter logic [127:0] INIT_A = "Fibo #?? is ????",
    parameter logic [127:0] INIT_B = "Fibo #?? is ????"
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_row,
    input  logic [4*N_REQ-1:0]         req_col,
    input  logic [N_REQ-1:0]           req_hex,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic                       clr,
    input  logic                       hold,
    output logic [127:0]               row_A,
    output logic [127:0]               row_B,
    output logic                       upd,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);
    localparam int IW = $clog2(N_REQ);

    logic [ROW_W-1:0] row_a_q, row_a_d;
    logic [ROW_W-1:0] row_b_q, row_b_d;
    logic             upd_q, upd_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             arb_en;
    logic             sel_row;
    logic [3:0]       sel_col;
    logic [7:0]       sel_data;
    logic [7:0]       sel_char;

    // Ready must fall combinationally with reset so nothing transfers on the reset edge
    assign arb_en = !(hold || clr || reset);

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req     (req_valid),
        .en      (arb_en),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign sel_row   = req_row[gnt_idx];
    assign sel_col   = req_col[int'(gnt_idx) * 4 +: 4];
    assign sel_data  = req_data[int'(gnt_idx) * 8 +: 8];
    assign sel_char  = req_hex[gnt_idx] ? hex2ascii(sel_data[3:0]) : sel_data;

    always_comb begin
        row_a_d    = row_a_q;
        row_b_d    = row_b_q;
        upd_d      = 1'b0;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (clr) begin
            row_a_d = {ROW_CHARS{ASCII_SPACE}};
            row_b_d = {ROW_CHARS{ASCII_SPACE}};
            upd_d   = 1'b1;
        end else if (|gnt) begin
            if (sel_row) begin
                row_b_d[col_lsb(sel_col) +: CHAR_W] = sel_char;
            end else begin
                row_a_d[col_lsb(sel_col) +: CHAR_W] = sel_char;
            end
            upd_d      = 1'b1;
            grant_id_d = gnt_idx;
            rr_ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_a_q    <= INIT_A;
            row_b_q    <= INIT_B;
            upd_q      <= 1'b0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            row_a_q    <= row_a_d;
            row_b_q    <= row_b_d;
            upd_q      <= upd_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign row_A    = row_a_q;
    assign row_B    = row_b_q;
    assign upd      = upd_q;
    assign grant_id = grant_id_q;

endmodule
